async_fifo_wr_status: RTL and testbench

ASYNC_FIFO_WR_STATUS -- requirements
Module: async_fifo_wr_status

---
 rtl/async_fifo_pkg.sv | 13 +
 rtl/async_fifo_gcodetobin.sv | 14 +
 rtl/async_fifo_wr_status.sv | 86 ++++++++
 tb/tb_async_fifo_wr_status.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async FIFO write-side status logic.
// Depth is derived from the gray pointer width (one extra wrap bit).
package async_fifo_pkg;

  localparam int DEFAULT_COUNTER_BITS = 4;
  localparam int DEFAULT_SYNC_STAGES  = 2;
  localparam int DEFAULT_AFULL_THRESH = 6;

  function automatic int fifo_depth(input int counter_bits);
    return 1 << (counter_bits - 1);
  endfunction

endpackage

// File: rtl/async_fifo_gcodetobin.sv
// Gray-code to binary converter, inverse of the binary-to-gray pointer encoder.
// Each binary bit is the XOR of all gray bits at or above it.
module async_fifo_gcodetobin #(
  parameter int SIGNAL_WIDTH = 4
) (
  input  logic [SIGNAL_WIDTH-1:0] greycode,
  output logic [SIGNAL_WIDTH-1:0] binary
);

  for (genvar i = 0; i < SIGNAL_WIDTH; i++) begin : g_bit
    assign binary[i] = ^greycode[SIGNAL_WIDTH-1:i];
  end

endmodule

// File: rtl/async_fifo_wr_status.sv
// Write-domain status for an async FIFO: read-pointer synchronizer, full,
// write enable, occupancy level, almost-full and sticky overflow.
module async_fifo_wr_status
  import async_fifo_pkg::*;
#(
  parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int AFULL_THRESH = DEFAULT_AFULL_THRESH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_req,
  input  logic                    ovf_clr,
  input  logic [COUNTER_BITS-1:0] wr_gcode_ptr,
  input  logic [COUNTER_BITS-1:0] rd_gcode_ptr,
  output logic                    wr_incr,
  output logic                    full,
  output logic                    almost_full,
  output logic [COUNTER_BITS-1:0] wr_level,
  output logic                    overflow
);

  localparam int MSB = COUNTER_BITS - 1;
  localparam int DEPTH = fifo_depth(COUNTER_BITS);
  localparam logic [COUNTER_BITS-1:0] AFULL_LVL = COUNTER_BITS'(AFULL_THRESH);

  logic [MSB:0] sync_q [SYNC_STAGES];
  logic [MSB:0] rd_gptr_sync;
  logic [MSB:0] wr_bin;
  logic [MSB:0] rd_bin;
  logic [MSB:0] level_next;
  logic         full_match;

  // Raw cross-domain capture in stage 0; nothing combinational in front of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_gcode_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rd_gptr_sync = sync_q[SYNC_STAGES-1];

  // Full when write pointer is one lap ahead: top two gray bits inverted.
  assign full_match = (wr_gcode_ptr == {~rd_gptr_sync[MSB:MSB-1], rd_gptr_sync[MSB-2:0]});
  assign full       = reset_n & full_match;
  assign wr_incr    = wr_req & ~full;

  async_fifo_gcodetobin #(.SIGNAL_WIDTH(COUNTER_BITS)) u_wr_g2b (
    .greycode (wr_gcode_ptr),
    .binary   (wr_bin)
  );

  async_fifo_gcodetobin #(.SIGNAL_WIDTH(COUNTER_BITS)) u_rd_g2b (
    .greycode (rd_gptr_sync),
    .binary   (rd_bin)
  );

  // Modular difference stays in 0..DEPTH across pointer rollover.
  assign level_next = wr_bin - rd_bin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_level    <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_level    <= level_next;
      almost_full <= (level_next >= AFULL_LVL);
      if (wr_req && full) overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

`ifdef ASSERT_ON
  a_no_write_when_full : assert property (@(posedge clk) disable iff (!reset_n)
    !(wr_incr && full));
  a_level_in_range : assert property (@(posedge clk) disable iff (!reset_n)
    wr_level <= COUNTER_BITS'(DEPTH));
  a_sync_one_bit : assert property (@(posedge clk) disable iff (!reset_n)
    $countones(rd_gptr_sync ^ $past(rd_gptr_sync)) <= 1);
`endif

endmodule

// File: tb/tb_async_fifo_wr_status.sv
// Directed and randomized checks of async_fifo_wr_status against an
// occupancy-count reference model with a data scoreboard.
module tb_async_fifo_wr_status;

  localparam int CB    = 4;
  localparam int DEPTH = 8;
  localparam int SS    = 2;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_req = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [CB-1:0] wr_gcode_ptr = '0;
  logic [CB-1:0] rd_gcode_ptr = '0;
  logic          wr_incr;
  logic          full;
  logic          almost_full;
  logic [CB-1:0] wr_level;
  logic          overflow;

  always #5 clk = ~clk;

  async_fifo_wr_status #(
    .COUNTER_BITS (CB),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (AF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_req       (wr_req),
    .ovf_clr      (ovf_clr),
    .wr_gcode_ptr (wr_gcode_ptr),
    .rd_gcode_ptr (rd_gcode_ptr),
    .wr_incr      (wr_incr),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow     (overflow)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: plain entry counts, no gray arithmetic.
  int         wr_total;
  int         rd_total;
  int         rd_hist[$];
  logic       exp_ovf;
  int         incr_cnt;
  logic       last_full;
  logic [7:0] mem [DEPTH];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [CB-1:0] to_gray(input int n);
    logic [CB-1:0] b;
    b = CB'(n);
    return b ^ (b >> 1);
  endfunction

  // Read count the write side can see: the value presented SS edges ago.
  function automatic int rd_seen();
    return (rd_hist.size() >= SS) ? rd_hist[rd_hist.size()-SS] : 0;
  endfunction

  task automatic cycle(input logic wr, input logic clr, input logic rd_adv);
    int   diff;
    logic e_full;
    logic dut_incr;
    logic [7:0] data;
    wr_req  = wr;
    ovf_clr = clr;
    #1;
    diff   = wr_total - rd_seen();
    e_full = (diff == DEPTH);
    chk("full", full, e_full);
    chk("wr_incr", wr_incr, wr && !e_full);
    last_full = full;
    dut_incr  = wr_incr;
    @(posedge clk);
    if (dut_incr) begin
      data = 8'($urandom);
      mem[wr_total % DEPTH] = data;
      exp_q.push_back(data);
      wr_total++;
      incr_cnt++;
    end
    if (wr && e_full) exp_ovf = 1'b1;
    else if (clr)     exp_ovf = 1'b0;
    rd_hist.push_back(rd_total);
    if (rd_hist.size() > SS) void'(rd_hist.pop_front());
    #1;
    wr_gcode_ptr = to_gray(wr_total);
    if (rd_adv && rd_total < wr_total) begin
      chk("data", mem[rd_total % DEPTH], exp_q.pop_front());
      rd_total++;
      rd_gcode_ptr = to_gray(rd_total);
    end
    chk("wr_level", wr_level, diff);
    chk("almost_full", almost_full, diff >= AF);
    chk("overflow", overflow, exp_ovf);
  endtask

  task automatic do_reset();
    wr_req  = 1'b0;
    ovf_clr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_level", wr_level, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", full, 0);
    wr_gcode_ptr = '0;
    rd_gcode_ptr = '0;
    wr_total = 0;
    rd_total = 0;
    rd_hist.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int   budget;
    int   rd_pct;
    int   wr_pct;
    logic full_pat [4];
    full_pat = '{1'b1, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b1;
    #1;
    do_reset();

    // Fill from empty with the read pointer parked at zero.
    incr_cnt = 0;
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    chk("fill_writes", incr_cnt, DEPTH);
    chk("fill_full", full, 1);
    chk("fill_level", wr_level, DEPTH);
    chk("fill_ovf", overflow, 1);

    // One read frees a slot only after the synchronizer delay.
    cycle(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk($sformatf("free_full_%0d", k), last_full, full_pat[k]);
    end

    // Set beats clear in the same cycle; clear alone then wins.
    cycle(1'b1, 1'b1, 1'b0);
    chk("ovf_set_wins", overflow, 1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", overflow, 0);

    // Drain to level 5 with overflow set, then reset mid-operation.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", wr_level, 5);
    chk("pre_rst_ovf", overflow, 1);
    do_reset();

    // Interleaved traffic with reads trailing by three across rollover.
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      cycle(1'b1, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      chk("wrap_level", wr_level, 3);
      chk("wrap_full", full, 0);
    end
    chk("wrap_rolled", int'(wr_total > 16), 1);

    // Randomized rate mix: 10k accepted writes.
    incr_cnt = 0;
    budget   = 0;
    rd_pct   = 50;
    wr_pct   = 50;
    while (incr_cnt < 10000 && budget < 60000) begin
      if (budget % 200 == 0) begin
        rd_pct = $urandom_range(30, 100);
        wr_pct = $urandom_range(30, 100);
      end
      cycle($urandom_range(1, 100) <= wr_pct,
            $urandom_range(1, 50) == 1,
            $urandom_range(1, 100) <= rd_pct);
      budget++;
    end
    chk("random_writes_done", int'(incr_cnt >= 10000), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
